// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker and the LFSR bench:
// checker state encoding and the counter sizing helper.
package prbs_pkg;

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Bits needed for a counter that must be able to hold the value threshold.
  function automatic int cnt_width(input int threshold);
    return $clog2(threshold + 1);
  endfunction

endpackage

// File: rtl/prbs_predict.sv
// Tap-XOR predictor: next expected bit from the history and the feedback polynomial.
module prbs_predict #(
  parameter int width = 3
) (
  input  logic [width-1:0] h,
  input  logic [width:1]   polynomial,
  output logic             p
);

  // polynomial[k] lines up with h[k-1], the bit consumed k cycles ago.
  assign p = ^(polynomial & h);

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: fills a history, hunts for a run of correct predictions,
// then free-runs its own predictor and counts mismatches while locked.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               width            = 3,
  parameter logic [width:0]   polynomial       = 4'b1011,
  parameter int               lock_threshold   = 8,
  parameter int               unlock_threshold = 4,
  parameter int               err_cnt_width    = 8
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     d_in,
  output logic                     locked,
  output logic                     error,
  output logic [err_cnt_width-1:0] err_cnt
);

  localparam int MatchW = cnt_width(lock_threshold);
  localparam int MissW  = cnt_width(unlock_threshold);
  localparam int FillW  = cnt_width(width);

  logic [1:0]               r_state;
  logic [width-1:0]         r_h;
  logic [FillW-1:0]         r_fill_cnt;
  logic [MatchW-1:0]        r_match_cnt;
  logic [MissW-1:0]         r_miss_cnt;
  logic                     r_locked;
  logic                     r_error;
  logic [err_cnt_width-1:0] r_err_cnt;

  logic w_p;
  logic w_match;

  prbs_predict #(
    .width(width)
  ) u_predict (
    .h          (r_h),
    .polynomial (polynomial[width:1]),
    .p          (w_p)
  );

  assign w_match = (d_in == w_p);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state     <= ST_FILL;
      r_h         <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_error <= 1'b0;
      if (clear) begin
        r_state     <= ST_FILL;
        r_h         <= '0;
        r_fill_cnt  <= '0;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
        r_locked    <= 1'b0;
        r_err_cnt   <= '0;
      end else if (enable) begin
        case (r_state)
          ST_FILL: begin
            r_h <= {r_h[width-2:0], d_in};
            if (r_fill_cnt == FillW'(width - 1)) begin
              r_state    <= ST_HUNT;
              r_fill_cnt <= '0;
            end else begin
              r_fill_cnt <= r_fill_cnt + 1'b1;
            end
          end
          ST_HUNT: begin
            r_h <= {r_h[width-2:0], d_in};
            // An all-zero history predicts zeros forever, so it must never count as a match.
            if ((r_h == '0) || !w_match) begin
              r_match_cnt <= '0;
            end else if (r_match_cnt == MatchW'(lock_threshold - 1)) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            // Feed back the prediction so a corrupted input bit is not multiplied.
            r_h <= {r_h[width-2:0], w_p};
            if (!w_match) begin
              r_error <= 1'b1;
              if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
              if (r_miss_cnt == MissW'(unlock_threshold - 1)) begin
                r_state     <= ST_HUNT;
                r_locked    <= 1'b0;
                r_miss_cnt  <= '0;
                r_match_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: begin
            r_state <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign locked  = r_locked;
  assign error   = r_error;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: x^3+x+1 reference stream 1001110 repeating,
// lock after 4 matches, unlock after 3 misses, 4-bit error counter.
module tb_prbs_checker;

  logic       clk;
  logic       res_n;
  logic       enable;
  logic       clear;
  logic       d_in;
  logic       locked;
  logic       error;
  logic [3:0] err_cnt;

  int   assertCount;
  int   failCount;
  int   refIdx;
  logic sawError;
  logic refBits [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  prbs_checker #(
    .width            (3),
    .polynomial       (4'b1011),
    .lock_threshold   (4),
    .unlock_threshold (3),
    .err_cnt_width    (4)
  ) dut (
    .clk     (clk),
    .res_n   (res_n),
    .enable  (enable),
    .clear   (clear),
    .d_in    (d_in),
    .locked  (locked),
    .error   (error),
    .err_cnt (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input logic bitIn, input logic en, input logic clr);
    d_in   = bitIn;
    enable = en;
    clear  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendRef(input logic flip);
    applyStimulus(refBits[refIdx] ^ flip, 1'b1, 1'b0);
    refIdx = (refIdx + 1) % 7;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic doReset(input string tag);
    res_n = 1'b0;
    #2;
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_error"}, error, 0);
    checkOutput({tag, "_errcnt"}, err_cnt, 0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    clear  = 1'b0;
    res_n  = 1'b1;
    refIdx = 0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    refIdx      = 0;
    res_n       = 1'b1;
    enable      = 1'b0;
    clear       = 1'b0;
    d_in        = 1'b0;
    #1;

    // Clean stream: lock on the 7th bit, no errors across 50 bits.
    doReset("rst");
    sawError = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      sendRef(1'b0);
      if (i <= 7) checkOutput($sformatf("lock_rise_%0d", i), locked, (i == 7));
      if (error) sawError = 1'b1;
    end
    checkOutput("clean_no_error", sawError, 0);
    checkOutput("clean_errcnt", err_cnt, 0);
    checkOutput("clean_locked", locked, 1);

    // One corrupted bit, then a stalled cycle, then clean bits.
    sendRef(1'b1);
    checkOutput("single_error", error, 1);
    checkOutput("single_errcnt", err_cnt, 1);
    checkOutput("single_locked", locked, 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hold_error", error, 0);
    checkOutput("hold_errcnt", err_cnt, 1);
    checkOutput("hold_locked", locked, 1);
    sawError = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sendRef(1'b0);
      if (error) sawError = 1'b1;
    end
    checkOutput("after_single_no_error", sawError, 0);
    checkOutput("after_single_errcnt", err_cnt, 1);
    checkOutput("after_single_locked", locked, 1);

    // Burst of three errors drops lock; four good bits re-lock.
    doReset("rst2");
    for (int i = 0; i < 7; i++) sendRef(1'b0);
    checkOutput("burst_pre_locked", locked, 1);
    for (int i = 1; i <= 3; i++) begin
      sendRef(1'b1);
      checkOutput($sformatf("burst_error_%0d", i), error, 1);
      checkOutput($sformatf("burst_errcnt_%0d", i), err_cnt, i);
      checkOutput($sformatf("burst_locked_%0d", i), locked, (i < 3));
    end
    for (int i = 1; i <= 4; i++) begin
      sendRef(1'b0);
      checkOutput($sformatf("relock_%0d", i), locked, (i == 4));
      checkOutput($sformatf("relock_error_%0d", i), error, 0);
    end
    checkOutput("relock_errcnt", err_cnt, 3);

    // All-zero stream must never lock.
    doReset("rst3");
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("zero_locked_%0d", i), locked, 0);
      checkOutput($sformatf("zero_errcnt_%0d", i), err_cnt, 0);
    end

    // Clear beats enable and restarts from FILL.
    doReset("rst4");
    for (int i = 0; i < 7; i++) sendRef(1'b0);
    for (int i = 0; i < 5; i++) begin
      sendRef(1'b1);
      sendRef(1'b0);
    end
    checkOutput("pre_clear_errcnt", err_cnt, 5);
    checkOutput("pre_clear_locked", locked, 1);
    applyStimulus(refBits[refIdx], 1'b1, 1'b1);
    refIdx = (refIdx + 1) % 7;
    checkOutput("clear_locked", locked, 0);
    checkOutput("clear_errcnt", err_cnt, 0);
    checkOutput("clear_error", error, 0);
    clear = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      sendRef(1'b0);
      checkOutput($sformatf("clear_relock_%0d", i), locked, (i == 7));
    end

    // Twenty isolated errors saturate the 4-bit counter at 15.
    for (int i = 1; i <= 20; i++) begin
      sendRef(1'b1);
      if (i == 15) checkOutput("sat_reach_15", err_cnt, 15);
      sendRef(1'b0);
    end
    checkOutput("sat_errcnt", err_cnt, 15);
    checkOutput("sat_locked", locked, 1);

    // Asynchronous reset in the middle of an error pulse.
    sendRef(1'b1);
    checkOutput("mid_error_before_reset", error, 1);
    doReset("mid_rst");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("post_reset_locked", locked, 0);
    checkOutput("post_reset_errcnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter width, default 3: LFSR length in bits, range 2..32.
REQ-002 Parameter polynomial, default 4'b1011: width+1 bits; bit k is the coefficient of x^k; bit 0 is ignored.
REQ-003 Parameter lock_threshold, default 8: consecutive matches needed to lock, range >=1.
REQ-004 Parameter unlock_threshold, default 4: consecutive mismatches while locked that drop lock, range >=1.
REQ-005 Parameter err_cnt_width, default 8: error counter width.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 res_n  input  1  reset, asynchronous, active-low.
REQ-008 enable  input  1  d_in is valid and is consumed this cycle.
REQ-009 clear  input  1  synchronous restart of state and counters.
REQ-010 d_in  input  1  serial bit from the upstream lfsr d_out.
REQ-011 locked  output  1  registered; high while synchronised.
REQ-012 error  output  1  registered; one-cycle pulse per mismatch while locked.
REQ-013 err_cnt  output  err_cnt_width  registered; saturating count of mismatches seen while locked.

Function
REQ-014 The block keeps a width-bit history h, in which h[k-1] is the bit consumed k enabled cycles earlier.
REQ-015 The predicted bit p is the XOR of h[k-1] over k=1..width where polynomial[k]=1.
REQ-016 The block has three states: FILL, HUNT, LOCKED; reset and clear both enter FILL.
REQ-017 FILL: each enabled bit shifts d_in into h; after width enabled bits the block enters HUNT; there is no comparison in FILL.
REQ-018 HUNT: each enabled bit is compared with p, d_in is shifted into h, a match increments match_cnt and a mismatch zeroes match_cnt.
REQ-019 HUNT: when h is all-zero, match_cnt is held at 0, so an all-zero stream never locks.
REQ-020 HUNT->LOCKED occurs on the edge at which match_cnt reaches lock_threshold; locked rises on that same edge.
REQ-021 LOCKED: p (not d_in) is shifted into h, so a corrupted bit causes exactly one mismatch and no error multiplication.
REQ-022 LOCKED, per enabled bit: on mismatch, error=1 for one cycle, err_cnt increments (saturating at all-ones) and miss_cnt increments; on match, miss_cnt is zeroed.
REQ-023 LOCKED->HUNT occurs on the edge at which miss_cnt reaches unlock_threshold; locked falls on that edge; h keeps its value; match_cnt=0; the error for that bit is still flagged and counted.
REQ-024 err_cnt is not cleared by a loss of lock; only reset or clear zero it.
REQ-025 enable=0: all state, counters and h are held, and error=0.
REQ-026 clear=1 has priority over enable: the bit is discarded; on the next edge state=FILL, h=0, all counters are 0, locked=0, error=0.
REQ-027 Latency: error and locked reflect a bit one clock after the edge at which it is sampled; there are no combinational input-to-output paths.

Reset
REQ-028 res_n=0 asynchronously forces state=FILL, h=0, match_cnt=0, miss_cnt=0, locked=0, error=0 and err_cnt=0, including in the middle of a stream.
REQ-029 After res_n is released, the block behaves exactly as after a clear.

Structure
REQ-030 The FILL/HUNT/LOCKED state encoding and the counter-width calculation (clog2 of each threshold+1) live in shared package prbs_pkg, which is reused by the lfsr bench.
REQ-031 The tap-XOR predictor is the sub-module prbs_predict (inputs: h and polynomial; output: p); everything else is in prbs_checker.

Verification
Bench parameters for all scenarios: width=3, polynomial=4'b1011, lock_threshold=4, unlock_threshold=3; reference stream is 1001110 repeating.
REQ-032 Reset, then stream with enable=1 -> locked rises after the 7th bit; error is never high; err_cnt=0 after 50 bits.
REQ-033 Locked, then invert one bit -> exactly one error pulse; err_cnt=1; locked stays 1.
REQ-034 Locked, then invert 3 consecutive bits -> err_cnt=3; locked falls after the 3rd; re-lock happens 4 good bits after the stream is re-aligned.
REQ-035 Reset, then 20 zero bits -> locked=0 and err_cnt=0 throughout.
REQ-036 Locked with err_cnt=5, then clear=1 and enable=1 in the same cycle -> next cycle locked=0 and err_cnt=0; re-lock after 7 further bits.
REQ-037 With err_cnt_width=4, 20 isolated errors -> err_cnt saturates at 15; res_n pulsed low mid-stream -> all outputs go to 0 before the next clk edge.
